// File: rtl/sdram_pkg.sv
// Shared types for the SDRAM arbiter: client port indices, FSM states
// and the command word handed to the SDRAM controller.
package sdram_pkg;

    localparam int SDRAM_ADDR_BITS = 22;
    localparam int SDRAM_PORTS     = 3;

    typedef enum logic [1:0] {
        PORT_PRG = 2'd0,
        PORT_CHR = 2'd1,
        PORT_MCU = 2'd2
    } port_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    typedef struct packed {
        logic                       we;
        logic [SDRAM_ADDR_BITS-1:0] address;
        logic [15:0]                data_write;
        logic [1:0]                 wm;
    } sdram_cmd_t;

endpackage

// File: rtl/sdram_req_slot.sv
// One-deep request slot for a single client port; a new req overwrites
// the held fields and always wins over a same-cycle clear from the arbiter.
module sdram_req_slot
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS = SDRAM_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] address,
    input  logic [15:0]          data_write,
    input  logic [1:0]           wm,
    input  logic                 clear,
    output logic                 pending,
    output logic                 cmd_we,
    output logic [ADDR_BITS-1:0] cmd_address,
    output logic [15:0]          cmd_data_write,
    output logic [1:0]           cmd_wm
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending        <= 1'b0;
            cmd_we         <= 1'b0;
            cmd_address    <= '0;
            cmd_data_write <= '0;
            cmd_wm         <= '0;
        end else if (req) begin
            pending        <= 1'b1;
            cmd_we         <= we;
            cmd_address    <= address;
            cmd_data_write <= data_write;
            cmd_wm         <= wm;
        end else if (clear) begin
            pending        <= 1'b0;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Three-client SDRAM arbiter: PRG has absolute priority, CHR and MCU share
// round-robin, and a single controller transaction is kept outstanding.
module sdram_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_BITS = SDRAM_ADDR_BITS,
    parameter int NPORTS    = SDRAM_PORTS
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NPORTS-1:0]                 cli_req,
    input  logic [NPORTS-1:0]                 cli_we,
    input  logic [NPORTS-1:0][ADDR_BITS-1:0]  cli_address,
    input  logic [NPORTS-1:0][15:0]           cli_data_write,
    input  logic [NPORTS-1:0][1:0]            cli_wm,
    output logic [NPORTS-1:0]                 cli_ack,
    output logic [NPORTS-1:0][15:0]           cli_data_read,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_BITS-1:0]              mem_address,
    output logic [15:0]                       mem_data_write,
    output logic [1:0]                        mem_wm,
    input  logic                              mem_ack,
    input  logic [15:0]                       mem_data_read
);

    state_t     state, next_state;
    port_t      win, grant;
    logic       rr_ptr;
    logic       grant_load;
    sdram_cmd_t cmd_reg;

    logic [NPORTS-1:0]                pending, slot_clear, slot_we;
    logic [NPORTS-1:0][ADDR_BITS-1:0] slot_address;
    logic [NPORTS-1:0][15:0]          slot_data_write;
    logic [NPORTS-1:0][1:0]           slot_wm;

    for (genvar i = 0; i < NPORTS; i++) begin : g_slot
        sdram_req_slot #(.ADDR_BITS(ADDR_BITS)) u_slot (
            .clk            (clk),
            .reset          (reset),
            .req            (cli_req[i]),
            .we             (cli_we[i]),
            .address        (cli_address[i]),
            .data_write     (cli_data_write[i]),
            .wm             (cli_wm[i]),
            .clear          (slot_clear[i]),
            .pending        (pending[i]),
            .cmd_we         (slot_we[i]),
            .cmd_address    (slot_address[i]),
            .cmd_data_write (slot_data_write[i]),
            .cmd_wm         (slot_wm[i])
        );
    end

    // rr_ptr low means CHR is preferred when CHR and MCU are both waiting.
    always_comb begin
        win = PORT_PRG;
        if (pending[0])                   win = PORT_PRG;
        else if (pending[1] && pending[2]) win = rr_ptr ? PORT_MCU : PORT_CHR;
        else if (pending[1])              win = PORT_CHR;
        else if (pending[2])              win = PORT_MCU;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        grant_load = 1'b0;
        slot_clear = '0;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    grant_load      = 1'b1;
                    slot_clear[win] = 1'b1;
                    next_state      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_req    = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_ack) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Command register only loads in IDLE, so mem fields stay put until the ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_reg       <= '0;
            grant         <= PORT_PRG;
            rr_ptr        <= 1'b0;
            cli_ack       <= '0;
            cli_data_read <= '0;
        end else begin
            cli_ack <= '0;
            if (grant_load) begin
                cmd_reg.we         <= slot_we[win];
                cmd_reg.address    <= SDRAM_ADDR_BITS'(slot_address[win]);
                cmd_reg.data_write <= slot_data_write[win];
                cmd_reg.wm         <= slot_wm[win];
                grant              <= win;
                if (win != PORT_PRG) rr_ptr <= ~rr_ptr;
            end
            if (state == ST_WAIT && mem_ack) begin
                cli_ack[grant] <= 1'b1;
                if (!cmd_reg.we) cli_data_read[grant] <= mem_data_read;
            end
        end
    end

    assign mem_we         = cmd_reg.we;
    assign mem_address    = ADDR_BITS'(cmd_reg.address);
    assign mem_data_write = cmd_reg.data_write;
    assign mem_wm         = cmd_reg.wm;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: a behavioural controller answers each
// mem_req, and expected issues/acks are queued as stimulus is driven.
module tb_sdram_arbiter;

    typedef struct {
        int          port;
        logic        we;
        logic [21:0] addr;
        logic [15:0] data;
        logic [1:0]  wm;
    } mem_exp_t;

    typedef struct {
        int          port;
        logic        rd;
        logic [15:0] data;
    } ack_exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        cli_req;
    logic [2:0]        cli_we;
    logic [2:0][21:0]  cli_address;
    logic [2:0][15:0]  cli_data_write;
    logic [2:0][1:0]   cli_wm;
    logic [2:0]        cli_ack;
    logic [2:0][15:0]  cli_data_read;
    logic              mem_req;
    logic              mem_we;
    logic [21:0]       mem_address;
    logic [15:0]       mem_data_write;
    logic [1:0]        mem_wm;
    logic              mem_ack;
    logic [15:0]       mem_data_read;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int req_cyc, issue_cyc, ack_drive_cyc;
    int issue_count = 0;
    int resp_cnt = 0;
    logic resp_busy = 1'b0, resp_ack_on = 1'b0, resp_aborted = 1'b0;
    logic [21:0] resp_addr;
    logic [18:0] resp_ctl;
    logic [15:0] shadow [3];
    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];

    sdram_arbiter #(.ADDR_BITS(22), .NPORTS(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .cli_req        (cli_req),
        .cli_we         (cli_we),
        .cli_address    (cli_address),
        .cli_data_write (cli_data_write),
        .cli_wm         (cli_wm),
        .cli_ack        (cli_ack),
        .cli_data_read  (cli_data_read),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_address    (mem_address),
        .mem_data_write (mem_data_write),
        .mem_wm         (mem_wm),
        .mem_ack        (mem_ack),
        .mem_data_read  (mem_data_read)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] rd_value(input logic [21:0] a);
        return a[15:0] ^ 16'hA54A;
    endfunction

    function automatic logic [21:0] port_addr(input int p, input int k);
        return 22'(32'h1000 + p * 256 + k);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        tick();
        cli_req = '0;
    endtask

    task automatic applyStimulus(input int p, input logic we, input logic [21:0] a,
                                 input logic [15:0] d, input logic [1:0] m);
        cli_req[p]        = 1'b1;
        cli_we[p]         = we;
        cli_address[p]    = a;
        cli_data_write[p] = d;
        cli_wm[p]         = m;
        req_cyc           = cyc;
    endtask

    task automatic expectIssue(input int p, input logic we, input logic [21:0] a,
                               input logic [15:0] d, input logic [1:0] m, input bit with_ack);
        mem_q.push_back('{port: p, we: we, addr: a, data: d, wm: m});
        if (with_ack) ack_q.push_back('{port: p, rd: !we, data: rd_value(a)});
    endtask

    task automatic waitDrain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (mem_q.size() == 0 && ack_q.size() == 0 && !resp_busy && !resp_ack_on) break;
            tick();
        end
        checkOutput(tag, 32'(mem_q.size() + ack_q.size()), 32'd0);
    endtask

    // Behavioural controller plus output monitor, sampling 1 ns after each edge.
    initial begin : monitor
        mem_exp_t me;
        ack_exp_t ae;
        logic     busy_before;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack_on) begin
                mem_ack     = 1'b0;
                resp_ack_on = 1'b0;
            end
            busy_before = resp_busy;
            if (resp_busy && reset) resp_aborted = 1'b1;
            if (resp_busy) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    if (!resp_aborted) begin
                        checkOutput("cmd_stable_addr", 32'(mem_address), 32'(resp_addr));
                        checkOutput("cmd_stable_ctl", 32'({mem_we, mem_data_write, mem_wm}), 32'(resp_ctl));
                    end
                    mem_ack       = 1'b1;
                    mem_data_read = rd_value(resp_addr);
                    resp_ack_on   = 1'b1;
                    resp_busy     = 1'b0;
                    ack_drive_cyc = cyc;
                end
            end
            if (mem_req) begin
                checkOutput("one_outstanding", 32'(busy_before), 32'd0);
                checkOutput("issue_expected", 32'(mem_q.size() > 0), 32'd1);
                if (mem_q.size() > 0) begin
                    me = mem_q.pop_front();
                    checkOutput("issue_addr", 32'(mem_address), 32'(me.addr));
                    checkOutput("issue_we", 32'(mem_we), 32'(me.we));
                    if (me.we) begin
                        checkOutput("issue_wdata", 32'(mem_data_write), 32'(me.data));
                        checkOutput("issue_wm", 32'(mem_wm), 32'(me.wm));
                    end
                end
                resp_busy    = 1'b1;
                resp_aborted = 1'b0;
                resp_cnt     = 4;
                resp_addr    = mem_address;
                resp_ctl     = {mem_we, mem_data_write, mem_wm};
                issue_cyc    = cyc;
                issue_count++;
            end
            if (cli_ack != 3'b000) begin
                checkOutput("ack_expected", 32'(ack_q.size() > 0), 32'd1);
                if (ack_q.size() > 0) begin
                    ae = ack_q.pop_front();
                    checkOutput("ack_port", 32'(cli_ack), 32'(3'b001 << ae.port));
                    checkOutput("ack_latency", 32'(cyc - ack_drive_cyc), 32'd1);
                    if (ae.rd) shadow[ae.port] = ae.data;
                    checkOutput("ack_data_read", 32'(cli_data_read[ae.port]), 32'(shadow[ae.port]));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int base, n1, n2;
        reset          = 1'b1;
        cli_req        = '0;
        cli_we         = '0;
        cli_address    = '0;
        cli_data_write = '0;
        cli_wm         = '0;
        mem_ack        = 1'b0;
        mem_data_read  = '0;
        for (int p = 0; p < 3; p++) shadow[p] = 16'h0000;

        repeat (3) tick();
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_address), 32'd0);
        checkOutput("rst_mem_ctl", 32'({mem_we, mem_data_write, mem_wm}), 32'd0);
        checkOutput("rst_cli_ack", 32'(cli_ack), 32'd0);
        for (int p = 0; p < 3; p++) checkOutput("rst_data_read", 32'(cli_data_read[p]), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        $display("[TB] single PRG read");
        expectIssue(0, 1'b0, 22'h000010, 16'h0000, 2'b11, 1'b1);
        applyStimulus(0, 1'b0, 22'h000010, 16'h0000, 2'b11);
        base = req_cyc;
        pulse();
        waitDrain("prg_read_drain");
        checkOutput("req_to_issue", 32'(issue_cyc - base), 32'd2);
        repeat (5) tick();
        checkOutput("prg_data_hold", 32'(cli_data_read[0]), 32'hA55A);

        $display("[TB] simultaneous requests on all ports");
        expectIssue(0, 1'b0, 22'h000100, 16'h0000, 2'b11, 1'b1);
        expectIssue(1, 1'b0, 22'h000200, 16'h0000, 2'b11, 1'b1);
        expectIssue(2, 1'b0, 22'h000300, 16'h0000, 2'b11, 1'b1);
        applyStimulus(0, 1'b0, 22'h000100, 16'h0000, 2'b11);
        applyStimulus(1, 1'b0, 22'h000200, 16'h0000, 2'b11);
        applyStimulus(2, 1'b0, 22'h000300, 16'h0000, 2'b11);
        pulse();
        waitDrain("all_ports_drain");

        $display("[TB] CHR/MCU continuous round-robin");
        for (int k = 0; k < 4; k++) begin
            expectIssue(1, 1'b0, port_addr(1, k), 16'h0000, 2'b11, 1'b1);
            expectIssue(2, 1'b0, port_addr(2, k), 16'h0000, 2'b11, 1'b1);
        end
        applyStimulus(1, 1'b0, port_addr(1, 0), 16'h0000, 2'b11);
        applyStimulus(2, 1'b0, port_addr(2, 0), 16'h0000, 2'b11);
        n1 = 1;
        n2 = 1;
        pulse();
        for (int i = 0; i < 400; i++) begin
            if (mem_q.size() == 0 && ack_q.size() == 0 && !resp_busy && !resp_ack_on) break;
            if (cli_ack[1] && n1 < 4) begin
                applyStimulus(1, 1'b0, port_addr(1, n1), 16'h0000, 2'b11);
                n1++;
            end
            if (cli_ack[2] && n2 < 4) begin
                applyStimulus(2, 1'b0, port_addr(2, n2), 16'h0000, 2'b11);
                n2++;
            end
            pulse();
        end
        checkOutput("rr_drain", 32'(mem_q.size() + ack_q.size()), 32'd0);

        $display("[TB] MCU write overwritten before grant");
        base = issue_count;
        expectIssue(0, 1'b0, 22'h000020, 16'h0000, 2'b11, 1'b1);
        expectIssue(2, 1'b1, 22'h3FFFFF, 16'h5678, 2'b01, 1'b1);
        applyStimulus(0, 1'b0, 22'h000020, 16'h0000, 2'b11);
        pulse();
        applyStimulus(2, 1'b1, 22'h3FFFFF, 16'h1234, 2'b01);
        pulse();
        applyStimulus(2, 1'b1, 22'h3FFFFF, 16'h5678, 2'b01);
        pulse();
        waitDrain("overwrite_drain");
        repeat (4) tick();
        checkOutput("overwrite_issue_count", 32'(issue_count - base), 32'd2);

        $display("[TB] CHR re-request on its grant cycle");
        expectIssue(1, 1'b0, 22'h004000, 16'h0000, 2'b11, 1'b1);
        expectIssue(1, 1'b1, 22'h004001, 16'h9999, 2'b10, 1'b1);
        applyStimulus(1, 1'b0, 22'h004000, 16'h0000, 2'b11);
        pulse();
        applyStimulus(1, 1'b1, 22'h004001, 16'h9999, 2'b10);
        pulse();
        waitDrain("regrant_drain");

        $display("[TB] stray controller ack while idle");
        base = issue_count;
        repeat (2) tick();
        mem_ack       = 1'b1;
        mem_data_read = 16'hBEEF;
        tick();
        mem_ack = 1'b0;
        repeat (3) tick();
        checkOutput("stray_no_issue", 32'(issue_count - base), 32'd0);
        for (int p = 0; p < 3; p++) checkOutput("stray_data_read", 32'(cli_data_read[p]), 32'(shadow[p]));

        $display("[TB] reset during WAIT");
        expectIssue(1, 1'b0, 22'h002222, 16'h0000, 2'b11, 1'b0);
        applyStimulus(1, 1'b0, 22'h002222, 16'h0000, 2'b11);
        pulse();
        for (int i = 0; i < 20; i++) begin
            if (mem_q.size() == 0) break;
            tick();
        end
        checkOutput("reset_issue_seen", 32'(mem_q.size()), 32'd0);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        for (int p = 0; p < 3; p++) shadow[p] = 16'h0000;
        waitDrain("reset_wait_drain");
        repeat (3) tick();
        checkOutput("post_rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("post_rst_mem_addr", 32'(mem_address), 32'd0);
        checkOutput("post_rst_mem_ctl", 32'({mem_we, mem_data_write, mem_wm}), 32'd0);
        checkOutput("post_rst_cli_ack", 32'(cli_ack), 32'd0);
        for (int p = 0; p < 3; p++) checkOutput("post_rst_data_read", 32'(cli_data_read[p]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
